// File: rtl/wb_gpio_irq_pkg.sv
// -----------------------------------------------------------------------------
// wb_gpio_irq_pkg
//
// Shared definitions for the wb_gpio_irq GPIO controller:
//   - DATA_W         : Wishbone data width (the register file is always 32 bits)
//   - reg_idx_e      : register word indices, decoded from adr[5:2]
//   - gpio_regs_t    : always-present register state (DIR, OUT)
//   - irq_regs_t     : interrupt register state (RISE_EN, FALL_EN, STATUS)
//   - width_mask()   : mask of the implemented pin bits for a given pin count
// -----------------------------------------------------------------------------
package wb_gpio_irq_pkg;

    localparam int DATA_W = 32;

    // Word indices of the register map (byte offset = index * 4).
    typedef enum logic [3:0] {
        REG_DIR     = 4'd0,
        REG_OUT     = 4'd1,
        REG_IN      = 4'd2,
        REG_OUT_SET = 4'd3,
        REG_OUT_CLR = 4'd4,
        REG_RISE_EN = 4'd5,
        REG_FALL_EN = 4'd6,
        REG_STATUS  = 4'd7
    } reg_idx_e;

    // Registers are stored full-width; bits above the pin count are kept at 0
    // by masking every write, so reads of those bits return 0 for free.
    typedef struct packed {
        logic [DATA_W-1:0] dir;
        logic [DATA_W-1:0] out;
    } gpio_regs_t;

    typedef struct packed {
        logic [DATA_W-1:0] rise_en;
        logic [DATA_W-1:0] fall_en;
        logic [DATA_W-1:0] status;
    } irq_regs_t;

    // Ones in the low w bits, zeros above. w is 1..32.
    function automatic logic [DATA_W-1:0] width_mask(input int unsigned w);
        if (w >= DATA_W) begin
            return '1;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/wishbone_p_if.sv
// -----------------------------------------------------------------------------
// wishbone_p_if
//
// Pipelined Wishbone bus bundle shared by masters and slaves on the peripheral
// bus. Signal names are from the slave's point of view (dat_i = write data into
// the slave, dat_o = read data out of the slave).
//   clk_i, rst_i : bus clock / reset (slaves may use their own reset)
//   adr, dat_i, sel, we, cyc, stb : request, master -> slave
//   dat_o, ack, stall             : response, slave -> master
// -----------------------------------------------------------------------------
interface wishbone_p_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          clk_i;
    logic          rst_i;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_i;
    logic [DW-1:0] dat_o;
    logic [DW/8-1:0] sel;
    logic          we;
    logic          cyc;
    logic          stb;
    logic          ack;
    logic          stall;

    modport slave (
        input  clk_i, rst_i, adr, dat_i, sel, we, cyc, stb,
        output dat_o, ack, stall
    );

    modport master (
        input  clk_i, rst_i, dat_o, ack, stall,
        output adr, dat_i, sel, we, cyc, stb
    );
endinterface

// File: rtl/generic_synchronizer.sv
// -----------------------------------------------------------------------------
// generic_synchronizer
//
// LEN-bit multi-flop synchroniser for asynchronous inputs. Each bit is
// synchronised independently; q follows d STAGES enabled edges later.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, all stages clear to 0
//   en    : shift enable (tie high for a free-running synchroniser)
//   d     : asynchronous input
//   q     : synchronised output
// -----------------------------------------------------------------------------
module generic_synchronizer #(
    parameter int LEN    = 1,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [LEN-1:0] d,
    output logic [LEN-1:0] q
);

    // stage_q[0] is the metastability-catching flop; stage_q[STAGES-1] is safe.
    logic [STAGES-1:0][LEN-1:0] stage_q;

    // NOTE: sequential state is assigned with <= so every stage samples the
    // value its neighbour held before the edge; blocking '=' here would
    // collapse the chain into a single flop.
    // NOTE: the stages are reset (unlike a storage array) so the synchronised
    // value is a defined 0 out of reset and downstream edge detection starts
    // from a known history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (en) begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/wb_gpio_irq.sv
// -----------------------------------------------------------------------------
// wb_gpio_irq
//
// Parametrised Wishbone GPIO controller with atomic set/clear output writes and
// optional per-pin edge interrupts.
//
// Parameters:
//   WIDTH       : number of GPIO pins, 1..32
//   SYNC_STAGES : input synchroniser depth, >= 2
//
// Ports:
//   clk_i   : system clock (same clock as wb.clk_i)
//   rst_ni  : asynchronous active-low reset (wb.rst_i is not used)
//   wb      : pipelined Wishbone slave; stall tied 0, registered ack/dat_o
//   gpio_io : tri-state pads, driven with OUT where DIR = 1
//   irq_o   : level interrupt, high while any STATUS bit is set
//
// Register map (word index = adr[5:2], full-word writes, sel ignored):
//   0x00 DIR  0x04 OUT  0x08 IN (RO)  0x0C OUT_SET (WO)  0x10 OUT_CLR (WO)
//   0x14 RISE_EN  0x18 FALL_EN  0x1C STATUS (W1C)  others read 0
//
// Build option:
//   WB_GPIO_IRQ_EN defined   : edge detection, RISE_EN, FALL_EN, STATUS, irq_o
//   WB_GPIO_IRQ_EN undefined : those registers read 0, irq_o tied 0
// -----------------------------------------------------------------------------
module wb_gpio_irq
    import wb_gpio_irq_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    wishbone_p_if.slave      wb,
    inout  wire [WIDTH-1:0]  gpio_io,
    output logic             irq_o
);

    localparam logic [DATA_W-1:0] PIN_MASK = width_mask(WIDTH);

    // -------------------------------------------------------------------------
    // Bus request decode
    // -------------------------------------------------------------------------
    logic              req;
    logic              wr_en;
    logic [3:0]        word_idx;
    logic [DATA_W-1:0] wdata;

    assign req      = wb.cyc & wb.stb;
    assign wr_en    = req & wb.we;
    assign word_idx = wb.adr[5:2];
    assign wdata    = wb.dat_i & PIN_MASK;

    assign wb.stall = 1'b0;

    // Bus bits this slave has no use for; the name keeps lint quiet about them.
    logic unused_bus;
    assign unused_bus = ^{wb.clk_i, wb.rst_i, wb.sel, wb.adr[31:6], wb.adr[1:0]};

    // -------------------------------------------------------------------------
    // Input synchroniser; IN also samples pins that this block is driving.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]  pin_sync;
    logic [DATA_W-1:0] in_word;

    generic_synchronizer #(
        .LEN    (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .en    (1'b1),
        .d     (gpio_io),
        .q     (pin_sync)
    );

    assign in_word = DATA_W'(pin_sync);

    // -------------------------------------------------------------------------
    // DIR / OUT registers
    // -------------------------------------------------------------------------
    gpio_regs_t gpio_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpio_q <= '0;
        end else if (wr_en) begin
            case (word_idx)
                REG_DIR:     gpio_q.dir <= wdata;
                REG_OUT:     gpio_q.out <= wdata;
                REG_OUT_SET: gpio_q.out <= gpio_q.out | wdata;
                REG_OUT_CLR: gpio_q.out <= gpio_q.out & ~wdata;
                default:     ;
            endcase
        end
    end

    // Pads: a pin drives OUT only while configured as an output.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign gpio_io[i] = gpio_q.dir[i] ? gpio_q.out[i] : 1'bz;
    end

`ifdef WB_GPIO_IRQ_EN
    // -------------------------------------------------------------------------
    // Edge detection and sticky status
    // -------------------------------------------------------------------------
    irq_regs_t         irq_q;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  fall;
    logic [DATA_W-1:0] edge_set;
    logic [DATA_W-1:0] status_clr;
    logic [DATA_W-1:0] status_next;
    logic              irq_q_flag;

    assign rise       = pin_sync & ~prev_q;
    assign fall       = ~pin_sync & prev_q;
    assign edge_set   = (DATA_W'(rise) & irq_q.rise_en) | (DATA_W'(fall) & irq_q.fall_en);
    assign status_clr = (wr_en && (word_idx == REG_STATUS)) ? wdata : '0;
    // Clear is applied first so a simultaneous new edge keeps the bit set.
    assign status_next = (irq_q.status & ~status_clr) | edge_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q      <= '0;
            prev_q     <= '0;
            irq_q_flag <= 1'b0;
        end else begin
            prev_q       <= pin_sync;
            irq_q.status <= status_next;
            // Registered copy of |STATUS so irq_o comes straight from a flop.
            irq_q_flag   <= |status_next;
            if (wr_en) begin
                case (word_idx)
                    REG_RISE_EN: irq_q.rise_en <= wdata;
                    REG_FALL_EN: irq_q.fall_en <= wdata;
                    default:     ;
                endcase
            end
        end
    end

    assign irq_o = irq_q_flag;
`else
    assign irq_o = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Read mux and registered response
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] rdata;

    // NOTE: rdata gets a default before the case so offsets without a register
    // (OUT_SET, OUT_CLR, unmapped) read 0 and no latch is inferred.
    always_comb begin
        rdata = '0;
        case (word_idx)
            REG_DIR:     rdata = gpio_q.dir;
            REG_OUT:     rdata = gpio_q.out;
            REG_IN:      rdata = in_word;
`ifdef WB_GPIO_IRQ_EN
            REG_RISE_EN: rdata = irq_q.rise_en;
            REG_FALL_EN: rdata = irq_q.fall_en;
            REG_STATUS:  rdata = irq_q.status;
`endif
            default:     rdata = '0;
        endcase
    end

    logic              ack_q;
    logic [DATA_W-1:0] dat_q;

    // One ack per accepted request, in the cycle after the accepting edge.
    // cyc low at an edge clears ack (aborted cycle); dat_o is 0 unless a read
    // is being acknowledged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            dat_q <= (req && !wb.we) ? rdata : '0;
        end
    end

    assign wb.ack   = ack_q;
    assign wb.dat_o = dat_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// -----------------------------------------------------------------------------
// tb_wb_gpio_irq
//
// Bench for wb_gpio_irq built with WIDTH = 24 so the unimplemented upper bits
// are exercised. A register-level model tracks DIR/OUT/enables/STATUS and the
// pad history, and a compare process checks ack, dat_o, irq_o and the driven
// pads on every falling edge. Directed sequences add literal expectations.
// Interrupt expectations follow WB_GPIO_IRQ_EN as seen by this file.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wb_gpio_irq;

    localparam int          W    = 24;
    localparam int          S    = 2;
    localparam logic [31:0] MASK = 32'h00FF_FFFF;
`ifdef WB_GPIO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wishbone_p_if wb_bus ();
    assign wb_bus.clk_i = clk;
    assign wb_bus.rst_i = ~rst_n;

    wire  [W-1:0] gpio;
    logic         irq;
    logic [W-1:0] ext_drv;

    // Model state
    logic [31:0]  m_dir, m_out, m_rise, m_fall, m_status;
    logic         exp_ack;
    logic [31:0]  exp_dat;
    logic         exp_irq;
    logic [W-1:0] pad_q[$];   // pad_q[k] = pad value sampled k edges ago

    int n_checks = 0;
    int n_fail   = 0;

    // The bench drives every pin the model says is an input, so pads are
    // never left floating.
    for (genvar i = 0; i < W; i++) begin : g_ext
        assign gpio[i] = m_dir[i] ? 1'bz : ext_drv[i];
    end

    wb_gpio_irq #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .wb      (wb_bus),
        .gpio_io (gpio),
        .irq_o   (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    task automatic m_reset();
        m_dir = '0; m_out = '0; m_rise = '0; m_fall = '0; m_status = '0;
        exp_ack = 1'b0; exp_dat = '0; exp_irq = 1'b0;
        pad_q.delete();
        for (int k = 0; k <= S; k++) pad_q.push_back('0);
    endtask

    task automatic m_step();
        logic [31:0] in_now, prev_now, pad_cur, rd, set, clr, d;
        logic        req;
        int          idx;
        // IN during the cycle just ended is the pad value S-1 edges back;
        // the value before that is what the edge detector compares against.
        in_now   = 32'(pad_q[S-1]);
        prev_now = 32'(pad_q[S]);
        pad_cur  = ((m_dir & m_out) | (~m_dir & 32'(ext_drv))) & MASK;
        pad_q.push_front(pad_cur[W-1:0]);
        void'(pad_q.pop_back());

        req = wb_bus.cyc & wb_bus.stb;
        idx = int'(wb_bus.adr[5:2]);
        case (idx)
            0:       rd = m_dir;
            1:       rd = m_out;
            2:       rd = in_now;
            5:       rd = m_rise;
            6:       rd = m_fall;
            7:       rd = m_status;
            default: rd = '0;
        endcase
        exp_ack = req;
        exp_dat = (req && !wb_bus.we) ? rd : '0;

        set = IRQ_ON ? ((in_now & ~prev_now & m_rise) | (~in_now & prev_now & m_fall)) : '0;
        clr = '0;
        if (req && wb_bus.we) begin
            d = wb_bus.dat_i & MASK;
            case (idx)
                0: m_dir = d;
                1: m_out = d;
                3: m_out = m_out | d;
                4: m_out = m_out & ~d;
                5: if (IRQ_ON) m_rise = d;
                6: if (IRQ_ON) m_fall = d;
                7: clr = d;
                default: ;
            endcase
        end
        m_status = (m_status & ~clr) | set;
        exp_irq  = |m_status;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("ack",   32'(wb_bus.ack), 32'(exp_ack));
            check("dat_o", wb_bus.dat_o, exp_dat);
            check("irq_o", 32'(irq), 32'(exp_irq));
            check("pads",  32'(gpio) & m_dir, m_out & m_dir);
        end
    end

    // ---------------------------------------------------------------- bus
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1; wb_bus.we = 1'b1;
        wb_bus.adr = a; wb_bus.dat_i = d;
        @(posedge clk); #1;
        check("wr_ack", 32'(wb_bus.ack), 32'd1);
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1; wb_bus.we = 1'b0; wb_bus.adr = a;
        @(posedge clk); #1;
        check("rd_ack", 32'(wb_bus.ack), 32'd1);
        d = wb_bus.dat_o;
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0;
    endtask

    // ---------------------------------------------------------------- main
    logic [31:0] d;
    logic [31:0] b_adr[4];
    logic [31:0] b_exp[4];

    initial begin
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
        wb_bus.adr = '0; wb_bus.dat_i = '0; wb_bus.sel = '1;
        ext_drv = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state: every offset reads 0, no interrupt.
        for (int k = 0; k < 8; k++) begin
            rd(32'(k * 4), d);
            check($sformatf("reset_rd_%02h", k * 4), d, 32'd0);
        end
        check("reset_irq", 32'(irq), 32'd0);

        // Pins come up as inputs: an external pattern reaches IN.
        ext_drv = 24'h5A5A5A;
        repeat (3) @(posedge clk);
        rd(32'h08, d);
        check("in_pattern", d, 32'h005A_5A5A);
        ext_drv = '0;
        repeat (3) @(posedge clk);

        // Output path with atomic set/clear.
        wr(32'h00, 32'h0000_00FF);
        wr(32'h04, 32'h0000_00A5);
        wr(32'h0C, 32'h0000_0100);
        wr(32'h00, 32'h0000_01FF);
        wr(32'h10, 32'h0000_0001);
        check("pads_out", 32'(gpio) & 32'h1FF, 32'h0000_01A4);
        rd(32'h04, d);
        check("out_rd", d, 32'h0000_01A4);

        // Pipelined burst of four reads, one ack per cycle.
        repeat (3) @(posedge clk);
        b_adr = '{32'h00, 32'h04, 32'h08, 32'h0C};
        b_exp = '{32'h1FF, 32'h1A4, 32'h1A4, 32'h0};
        @(posedge clk); #1;
        wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1; wb_bus.we = 1'b0; wb_bus.adr = b_adr[0];
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("burst_ack%0d", k - 1), 32'(wb_bus.ack), 32'd1);
            check($sformatf("burst_dat%0d", k - 1), wb_bus.dat_o, b_exp[k - 1]);
            if (k < 4) wb_bus.adr = b_adr[k];
        end
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0;

        // Abort: cyc dropped with stb still high -> ack low after next edge.
        @(posedge clk); #1;
        wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1; wb_bus.adr = 32'h00;
        @(posedge clk); #1;
        check("abort_ack_pre", 32'(wb_bus.ack), 32'd1);
        wb_bus.cyc = 1'b0;
        @(posedge clk); #1;
        check("abort_ack", 32'(wb_bus.ack), 32'd0);
        wb_bus.stb = 1'b0;

        // Unimplemented pin bits and unmapped offsets.
        wr(32'h00, 32'hFFFF_FFFF);
        rd(32'h00, d);
        check("dir_mask", d, 32'h00FF_FFFF);
        wr(32'h20, 32'hFFFF_FFFF);
        rd(32'h20, d);
        check("unmapped_20", d, 32'd0);
        rd(32'h3C, d);
        check("unmapped_3c", d, 32'd0);

        // Rising edge on pin 3.
        wr(32'h00, 32'h0);
        repeat (4) @(posedge clk);
        wr(32'h14, 32'h8);
        @(posedge clk); #1;
        ext_drv[3] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("irq_before_rise", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("irq_rise", 32'(irq), 32'(IRQ_ON));
        rd(32'h1C, d);
        check("status_rise", d, IRQ_ON ? 32'h8 : 32'h0);
        rd(32'h08, d);
        check("in_pin3", d & 32'h8, 32'h8);
        wr(32'h1C, 32'h8);
        check("irq_w1c", 32'(irq), 32'd0);

        // Falling edge on pin 5 colliding with a W1C of bit 5: set wins.
        wr(32'h18, 32'h20);
        ext_drv[5] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        ext_drv[5] = 1'b0;
        @(posedge clk);
        wr(32'h1C, 32'h20);
        check("irq_set_wins", 32'(irq), 32'(IRQ_ON));
        rd(32'h1C, d);
        check("status_set_wins", d, IRQ_ON ? 32'h20 : 32'h0);
        wr(32'h1C, 32'h20);
        check("irq_final_clr", 32'(irq), 32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
